editor_campo_bcd: RTL and testbench

//  Downstream consumer of the cursor-position stage. Holds the ten editable BCD time fields:

---
 rtl/editor_campo_bcd.sv | 145 ++++++++++++++
 tb/tb_editor_campo_bcd.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/editor_campo_bcd.sv
// Editable BCD time fields (chronometer, time, date) with up/down editing,
// write-back to the RTC controller over req/ack, and combinational display reads.
module editor_campo_bcd #(
  parameter int unsigned DIR_W    = 8,
  parameter logic [7:0]  DAY_MAX  = 8'h31,
  parameter logic [7:0]  YEAR_MAX = 8'h99
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIR_W-1:0] dir_in,
  input  logic             push_up,
  input  logic             push_down,
  output logic             wr_req,
  output logic [DIR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic             wr_ack,
  output logic             busy,
  input  logic [DIR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam int unsigned NFIELD = 10;

  typedef enum logic [1:0] {IDLE, UPD, WREQ} state_t;

  state_t             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               up_q, up_d;
  logic               wr_req_q, wr_req_d;
  logic [DIR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [7:0]         field_q [NFIELD];
  logic [7:0]         field_d [NFIELD];

  logic [3:0]         idx;
  logic [7:0]         cur_val;
  logic [7:0]         new_val;
  logic               dir_ok;
  logic               rd_ok;
  logic [3:0]         rd_idx;

  // Minimum value of each field; also its reset value.
  function automatic logic [7:0] fmin(input logic [3:0] i);
    return (i == 4'd7 || i == 4'd8) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] fmax(input logic [3:0] i);
    case (i)
      4'd0, 4'd4:             return 8'h23;
      4'd1, 4'd2, 4'd5, 4'd6: return 8'h59;
      4'd3:                   return 8'h01;
      4'd7:                   return DAY_MAX;
      4'd8:                   return 8'h12;
      4'd9:                   return YEAR_MAX;
      default:                return 8'h00;
    endcase
  endfunction

  // Nibble-wise BCD step with decimal carry/borrow and field wrap.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi, input logic up);
    logic [7:0] r;
    if (up) begin
      if (v == hi)              r = lo;
      else if (v[3:0] == 4'h9)  r = {v[7:4] + 4'h1, 4'h0};
      else                      r = {v[7:4], v[3:0] + 4'h1};
    end else begin
      if (v == lo)              r = hi;
      else if (v[3:0] == 4'h0)  r = {v[7:4] - 4'h1, 4'h9};
      else                      r = {v[7:4], v[3:0] - 4'h1};
    end
    return r;
  endfunction

  assign dir_ok  = (dir_in >= DIR_W'(1)) && (dir_in <= DIR_W'(NFIELD));
  assign idx     = dir_q[3:0] - 4'd1;
  assign cur_val = (idx < 4'(NFIELD)) ? field_q[idx] : 8'h00;
  assign new_val = bcd_step(cur_val, fmin(idx), fmax(idx), up_q);

  // Next-state and write-port logic.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    up_d      = up_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    field_d   = field_q;
    case (state_q)
      IDLE: begin
        if (enable && (push_up ^ push_down) && dir_ok) begin
          dir_d   = dir_in;
          up_d    = push_up;
          state_d = UPD;
        end
      end
      UPD: begin
        if (idx < 4'(NFIELD)) field_d[idx] = new_val;
        wr_addr_d = dir_q;
        wr_data_d = new_val;
        wr_req_d  = 1'b1;
        state_d   = WREQ;
      end
      WREQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= '0;
      up_q      <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      for (int unsigned i = 0; i < NFIELD; i++) field_q[i] <= fmin(4'(i));
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      up_q      <= up_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      field_q   <= field_d;
    end
  end

  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != IDLE);

  // Display read port; out-of-range addresses read as zero.
  assign rd_ok   = (rd_addr >= DIR_W'(1)) && (rd_addr <= DIR_W'(NFIELD));
  assign rd_idx  = rd_addr[3:0] - 4'd1;
  assign rd_data = rd_ok ? field_q[rd_idx] : 8'h00;

endmodule

// File: tb/tb_editor_campo_bcd.sv
// Directed bench for editor_campo_bcd with a decimal reference model and a write scoreboard.
module tb_editor_campo_bcd;

  logic       clk = 1'b0;
  logic       reset, enable, push_up, push_down, wr_ack;
  logic [7:0] dir_in, rd_addr;
  logic       wr_req, busy;
  logic [7:0] wr_addr, wr_data, rd_data;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int model  [1:10];
  int lim_lo [1:10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  int lim_hi [1:10] = '{23, 59, 59, 1, 23, 59, 59, 31, 12, 99};

  editor_campo_bcd dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in),
    .push_up(push_up), .push_down(push_down), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 1; i <= 10; i++) model[i] = lim_lo[i];
  endtask

  task automatic check_field(input int f);
    rd_addr = 8'(f);
    #1;
    check($sformatf("rd_field%0d", f), rd_data, to_bcd(model[f]));
  endtask

  // One accepted push; ack is raised after ack_dly request cycles, optional push while busy.
  task automatic do_push(input int f, input bit up, input int ack_dly, input bit extra);
    wr_t e;
    int  nv;
    bit  seen;
    @(negedge clk);
    dir_in = 8'(f); push_up = up; push_down = !up;
    if (up) nv = (model[f] == lim_hi[f]) ? lim_lo[f] : model[f] + 1;
    else    nv = (model[f] == lim_lo[f]) ? lim_hi[f] : model[f] - 1;
    model[f] = nv;
    e.addr = 8'(f); e.data = to_bcd(nv);
    exp_q.push_back(e);
    @(negedge clk);
    push_up = 1'b0; push_down = 1'b0; dir_in = 8'h03;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (wr_req) begin seen = 1'b1; break; end
    end
    check("wr_req_rise", 8'(seen), 8'h01);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_addr", wr_addr, e.addr);
      check("wr_data", wr_data, e.data);
    end
    check("busy_wreq", 8'(busy), 8'h01);
    check_field(f);
    for (int k = 0; k < ack_dly; k++) begin
      if (extra && k == 1) begin push_up = 1'b1; dir_in = 8'(f); end
      @(negedge clk);
      push_up = 1'b0;
      check("wr_req_hold", 8'(wr_req), 8'h01);
      check("wr_data_hold", wr_data, e.data);
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    check("wr_req_drop", 8'(wr_req), 8'h00);
    check("busy_idle", 8'(busy), 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_extra_write", 8'(wr_req), 8'h00);
    end
    check_field(f);
  endtask

  // Stimulus that must not start a transaction.
  task automatic no_action(input int f, input bit up, input bit dn, input bit en, input logic [7:0] d);
    @(negedge clk);
    dir_in = d; push_up = up; push_down = dn; enable = en;
    @(negedge clk);
    push_up = 1'b0; push_down = 1'b0; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ignored_wr_req", 8'(wr_req), 8'h00);
      check("ignored_busy", 8'(busy), 8'h00);
    end
    check_field(f);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; push_up = 1'b0; push_down = 1'b0; wr_ack = 1'b0;
    dir_in = 8'h00; rd_addr = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_wr_req", 8'(wr_req), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check_field(8);
    check_field(5);
    rd_addr = 8'd11; #1;
    check("rd_out_of_range", rd_data, 8'h00);

    do_push(6, 1'b0, 0, 1'b0);                       // 00 -> 59
    do_push(6, 1'b1, 3, 1'b0);                       // 59 -> 00, ack after 3 cycles
    do_push(9, 1'b0, 1, 1'b0);                       // month 01 -> 12
    for (int i = 0; i < 10; i++) do_push(7, 1'b1, 0, 1'b0);
    do_push(7, 1'b0, 0, 1'b0);                       // 10 -> 09
    do_push(8, 1'b0, 0, 1'b0);                       // day 01 -> 31
    do_push(8, 1'b1, 0, 1'b0);
    do_push(10, 1'b0, 0, 1'b0);                      // year 00 -> 99
    do_push(4, 1'b1, 0, 1'b0);
    do_push(4, 1'b1, 0, 1'b0);
    do_push(1, 1'b0, 0, 1'b0);                       // hh 00 -> 23
    do_push(1, 1'b1, 2, 1'b0);

    no_action(5, 1'b1, 1'b1, 1'b1, 8'd5);
    no_action(5, 1'b1, 1'b0, 1'b1, 8'd0);
    no_action(10, 1'b0, 1'b1, 1'b1, 8'd11);
    no_action(5, 1'b1, 1'b0, 1'b0, 8'd5);

    do_push(3, 1'b1, 5, 1'b1);                       // push during WREQ dropped

    @(negedge clk);
    dir_in = 8'd2; push_up = 1'b1;
    @(negedge clk);
    push_up = 1'b0;
    @(negedge clk);
    check("pre_reset_wr_req", 8'(wr_req), 8'h01);
    #2 reset = 1'b1;
    #1;
    check("async_rst_wr_req", 8'(wr_req), 8'h00);
    check("async_rst_busy", 8'(busy), 8'h00);
    model_reset();
    check_field(2);
    check_field(8);
    check_field(9);
    check_field(10);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_wr_req", 8'(wr_req), 8'h00);
    end
    do_push(5, 1'b1, 0, 1'b0);

    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
